alu_stage_mc: RTL and testbench

Parametrised successor to the single-cycle ALU pipeline stage. It sits between register-read/operand select and the MEM stage. It adds a valid/ready handshake with backpressure, a synchronous flush, and an iterative multi-cycle multiplier. All downstream fields (pc, id, y, d) are registered, and a NOP instruction word is presented whenever the output slot is empty.

---
 rtl/alu_stage_mc.sv | 187 ++++++++++++++++++
 tb/tb_alu_stage_mc.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stage_mc.sv
// ALU pipeline stage with valid/ready handshake, synchronous flush and an
// iterative shift-add multiplier retiring MUL_BITS multiplier bits per cycle.
module alu_stage_mc #(
  parameter int              WIDTH    = 32,
  parameter int              ID_W     = 32,
  parameter int              MUL_BITS = 2,
  parameter logic [ID_W-1:0] NOP      = 32'h83fff800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [ID_W-1:0]  in_id,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_d,
  input  logic [5:0]       in_fn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [ID_W-1:0]  out_id,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_d,
  output logic             busy
);

  localparam int MUL_STEPS = WIDTH / MUL_BITS;
  localparam int SH_W      = $clog2(WIDTH);
  localparam int CNT_W     = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

  localparam logic [5:0] FN_ADD   = 6'h00;
  localparam logic [5:0] FN_SUB   = 6'h01;
  localparam logic [5:0] FN_MUL   = 6'h02;
  localparam logic [5:0] FN_CMPEQ = 6'h04;
  localparam logic [5:0] FN_CMPLT = 6'h05;
  localparam logic [5:0] FN_CMPLE = 6'h06;
  localparam logic [5:0] FN_AND   = 6'h08;
  localparam logic [5:0] FN_OR    = 6'h09;
  localparam logic [5:0] FN_XOR   = 6'h0A;
  localparam logic [5:0] FN_XNOR  = 6'h0B;
  localparam logic [5:0] FN_PASSA = 6'h0C;
  localparam logic [5:0] FN_SHL   = 6'h10;
  localparam logic [5:0] FN_SHR   = 6'h11;
  localparam logic [5:0] FN_SRA   = 6'h12;

  typedef enum logic {S_RUN, S_MUL} state_t;

  function automatic logic [WIDTH-1:0] alu_fn(input logic [5:0]       fn,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [SH_W-1:0]         sh;
    sa     = a;
    sb     = b;
    sh     = b[SH_W-1:0];
    alu_fn = '0;
    case (fn)
      FN_ADD:   alu_fn = a + b;
      FN_SUB:   alu_fn = a - b;
      FN_CMPEQ: alu_fn = {{(WIDTH-1){1'b0}}, (a == b)};
      FN_CMPLT: alu_fn = {{(WIDTH-1){1'b0}}, (sa < sb)};
      FN_CMPLE: alu_fn = {{(WIDTH-1){1'b0}}, (sa <= sb)};
      FN_AND:   alu_fn = a & b;
      FN_OR:    alu_fn = a | b;
      FN_XOR:   alu_fn = a ^ b;
      FN_XNOR:  alu_fn = ~(a ^ b);
      FN_PASSA: alu_fn = a;
      FN_SHL:   alu_fn = a << sh;
      FN_SHR:   alu_fn = a >> sh;
      FN_SRA:   alu_fn = sa >>> sh;
      default:  alu_fn = '0;
    endcase
  endfunction

  // Low WIDTH bits of mcand times a MUL_BITS-wide multiplier digit.
  function automatic logic [WIDTH-1:0] mul_pp(input logic [WIDTH-1:0]    mcand,
                                              input logic [MUL_BITS-1:0] digit);
    mul_pp = '0;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (digit[j]) mul_pp = mul_pp + (mcand << j);
    end
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt_p0;
  logic [WIDTH-1:0] acc_p0;
  logic [WIDTH-1:0] mcand_p0;
  logic [WIDTH-1:0] mplier_p0;
  logic [WIDTH-1:0] pc_p0;
  logic [ID_W-1:0]  id_p0;
  logic [WIDTH-1:0] d_p0;

  logic             slot_free;
  logic             accept;
  logic             is_mul;
  logic             mul_last;
  logic             mul_done;
  logic [WIDTH-1:0] pp;

  assign slot_free = ~out_valid | out_ready;
  assign in_ready  = (state == S_RUN) & slot_free & ~flush;
  assign accept    = in_ready & in_valid;
  assign is_mul    = (in_fn == FN_MUL);
  assign mul_last  = (state == S_MUL) & (cnt_p0 == CNT_LAST);
  assign mul_done  = mul_last & slot_free & ~flush;
  assign pp        = mul_pp(mcand_p0, mplier_p0[MUL_BITS-1:0]);
  assign busy      = (state == S_MUL);

  // Stage p0: multiplier operand capture and shift-add iteration
  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      acc_p0    <= '0;
      mcand_p0  <= in_a;
      mplier_p0 <= in_b;
      pc_p0     <= in_pc;
      id_p0     <= in_id;
      d_p0      <= in_d;
    end else if ((state == S_MUL) && !mul_last) begin
      acc_p0    <= acc_p0 + pp;
      mcand_p0  <= mcand_p0 << MUL_BITS;
      mplier_p0 <= mplier_p0 >> MUL_BITS;
    end
  end

  // Output slot: loads on accept or multiply completion, drains on out_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RUN;
      cnt_p0    <= '0;
      out_valid <= 1'b0;
      out_id    <= NOP;
      out_pc    <= '0;
      out_y     <= '0;
      out_d     <= '0;
    end else if (flush) begin
      state     <= S_RUN;
      cnt_p0    <= '0;
      out_valid <= 1'b0;
      out_id    <= NOP;
    end else begin
      case (state)
        S_RUN: begin
          if (accept && !is_mul) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            out_id    <= in_id;
            out_y     <= alu_fn(in_fn, in_a, in_b);
            out_d     <= in_d;
          end else begin
            if (accept) begin
              state  <= S_MUL;
              cnt_p0 <= '0;
            end
            if (out_ready) begin
              out_valid <= 1'b0;
              out_id    <= NOP;
            end
          end
        end
        S_MUL: begin
          if (mul_done) begin
            out_valid <= 1'b1;
            out_pc    <= pc_p0;
            out_id    <= id_p0;
            out_y     <= acc_p0 + pp;
            out_d     <= d_p0;
            state     <= S_RUN;
            cnt_p0    <= '0;
          end else begin
            // The final digit waits here, counter frozen, until the slot frees.
            if (!mul_last) cnt_p0 <= cnt_p0 + 1'b1;
            if (out_ready) begin
              out_valid <= 1'b0;
              out_id    <= NOP;
            end
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_stage_mc.sv
// Directed and random stimulus for alu_stage_mc; a negedge monitor checks every
// delivered result against a queue of expected transactions.
module tb_alu_stage_mc;

  localparam logic [31:0] NOP = 32'h83fff800;

  logic        clk, rst, flush;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_pc, in_id, in_a, in_b, in_d;
  logic [5:0]  in_fn;
  logic [31:0] out_pc, out_id, out_y, out_d;

  alu_stage_mc #(.WIDTH(32), .ID_W(32), .MUL_BITS(2), .NOP(32'h83fff800)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_id(in_id), .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_fn(in_fn),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_id(out_id), .out_y(out_y), .out_d(out_d),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] id;
    logic [31:0] y;
    logic [31:0] d;
  } txn_t;

  txn_t q[$];
  txn_t sb_exp;
  txn_t sb_push;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [31:0] exp_result(input logic [5:0] fn, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    case (fn)
      6'h00: return a + b;
      6'h01: return a - b;
      6'h02: return prod[31:0];
      6'h04: return (a == b) ? 32'd1 : 32'd0;
      6'h05: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h06: return ($signed(a) <= $signed(b)) ? 32'd1 : 32'd0;
      6'h08: return a & b;
      6'h09: return a | b;
      6'h0A: return a ^ b;
      6'h0B: return ~(a ^ b);
      6'h0C: return a;
      6'h10: return a << b[4:0];
      6'h11: return a >> b[4:0];
      6'h12: return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [31:0] id,
                       input logic [31:0] d);
    in_valid = v;
    in_fn    = fn;
    in_a     = a;
    in_b     = b;
    in_pc    = pc;
    in_id    = id;
    in_d     = d;
  endtask

  always @(negedge clk) begin
    if (rst || flush) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_cmp++;
        assert (q.size() != 0) else begin
          n_err++;
          $error("FAIL sb_underflow: observed empty queue, expected a pending result");
        end
        if (q.size() != 0) begin
          sb_exp = q.pop_front();
          chk("sb_txn", {out_pc, out_id, out_y, out_d}, sb_exp);
        end
      end
      if (!out_valid) chk("sb_empty_id", out_id, NOP);
      if (in_valid && in_ready) begin
        sb_push.pc = in_pc;
        sb_push.id = in_id;
        sb_push.y  = exp_result(in_fn, in_a, in_b);
        sb_push.d  = in_d;
        q.push_back(sb_push);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic [5:0]  fn_tab [16] = '{6'h00, 6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h08, 6'h09,
                               6'h0A, 6'h0B, 6'h0C, 6'h10, 6'h11, 6'h12, 6'h03, 6'h3F};
  int          busy_cnt;
  logic        acc;
  int          tries;
  logic [31:0] ra, rb, mexp;
  logic [5:0]  rfn;

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 6'h00, 0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_id", out_id, NOP);
    chk("rst_busy", busy, 1'b0);
    chk("rst_y", out_y, 32'd0);
    rst = 1'b0;
    step();
    chk("rst_in_ready", in_ready, 1'b1);

    // Back-to-back at full throughput
    drive(1'b1, 6'h00, 32'd5, 32'd7, 32'h100, 32'h00000013, 32'hD0);
    #1 chk("b2b_rdy_add", in_ready, 1'b1);
    step();
    chk("b2b_add_y", out_y, 32'd12);
    chk("b2b_add_valid", out_valid, 1'b1);
    drive(1'b1, 6'h01, 32'd3, 32'd5, 32'h104, 32'h00000023, 32'hD1);
    #1 chk("b2b_rdy_sub", in_ready, 1'b1);
    step();
    chk("b2b_sub_y", out_y, 32'hFFFFFFFE);
    drive(1'b1, 6'h12, 32'h80000000, 32'd4, 32'h108, 32'h00000033, 32'hD2);
    #1 chk("b2b_rdy_sra", in_ready, 1'b1);
    step();
    chk("b2b_sra_y", out_y, 32'hF8000000);
    chk("b2b_sra_pc", out_pc, 32'h108);
    in_valid = 1'b0;
    step();
    chk("b2b_drain_valid", out_valid, 1'b0);
    chk("b2b_drain_id", out_id, NOP);

    // Backpressure holds the result and blocks the next op
    out_ready = 1'b0;
    drive(1'b1, 6'h05, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h00000043, 32'hE0);
    step();
    drive(1'b1, 6'h0A, 32'h0000F0F0, 32'h00000FF0, 32'h204, 32'h00000053, 32'hE1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_y_held", out_y, 32'd1);
      chk("bp_pc_held", out_pc, 32'h200);
      chk("bp_valid_held", out_valid, 1'b1);
      step();
    end
    out_ready = 1'b1;
    #1 chk("bp_rdy_rise", in_ready, 1'b1);
    step();
    chk("bp_next_y", out_y, 32'h0000FF00);
    chk("bp_next_pc", out_pc, 32'h204);
    in_valid = 1'b0;
    step();

    // Multiply latency and result
    drive(1'b1, 6'h02, 32'h00010001, 32'h00010003, 32'h300, 32'h00000063, 32'hF0);
    #1 chk("mul_rdy_issue", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    busy_cnt = 0;
    while (busy && busy_cnt < 40) begin
      busy_cnt++;
      chk("mul_in_ready_low", in_ready, 1'b0);
      step();
    end
    chk("mul_busy_cycles", busy_cnt, 16);
    chk("mul_valid", out_valid, 1'b1);
    chk("mul_y", out_y, 32'h00040003);
    chk("mul_pc", out_pc, 32'h300);
    chk("mul_id", out_id, 32'h00000063);
    step();

    // Multiply completing into a stalled consumer
    ra = 32'h0001E240;
    rb = 32'hFFFFFF85;
    mexp = exp_result(6'h02, ra, rb);
    drive(1'b1, 6'h02, ra, rb, 32'h310, 32'h00000073, 32'hF1);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    busy_cnt = 0;
    while (busy && busy_cnt < 40) begin
      busy_cnt++;
      step();
    end
    chk("mulst_busy_cycles", busy_cnt, 16);
    for (int i = 0; i < 3; i++) begin
      chk("mulst_valid", out_valid, 1'b1);
      chk("mulst_y", out_y, mexp);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("mulst_drained", out_valid, 1'b0);

    // Flush mid-multiply, then a fresh ADD
    drive(1'b1, 6'h02, 32'h0000FFFF, 32'h0000FFFF, 32'h320, 32'h00000083, 32'hF2);
    step();
    in_valid = 1'b0;
    repeat (7) step();
    chk("fl_busy_before", busy, 1'b1);
    flush = 1'b1;
    drive(1'b1, 6'h00, 32'd1, 32'd1, 32'h400, 32'h00000093, 32'hA0);
    #1 chk("fl_in_ready", in_ready, 1'b0);
    step();
    flush = 1'b0;
    chk("fl_busy", busy, 1'b0);
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_id", out_id, NOP);
    #1 chk("fl_rdy_after", in_ready, 1'b1);
    step();
    chk("fl_add_y", out_y, 32'd2);
    chk("fl_add_pc", out_pc, 32'h400);
    in_valid = 1'b0;
    step();

    // Flush kills a result stuck in the output slot
    out_ready = 1'b0;
    drive(1'b1, 6'h09, 32'h00F0, 32'h0F00, 32'h410, 32'h000000A3, 32'hA1);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flhold_valid", out_valid, 1'b0);
    chk("flhold_id", out_id, NOP);
    out_ready = 1'b1;
    step();

    // Random ops under random backpressure
    for (int k = 0; k < 60; k++) begin
      rfn = fn_tab[$urandom_range(0, 15)];
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      drive(1'b1, rfn, ra, rb, 32'h1000 + 32'(k * 4), $urandom, $urandom);
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 100) begin
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        acc = in_ready;
        @(posedge clk);
        #1;
        tries++;
      end
      chk("rnd_accepted", acc, 1'b1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (40) step();
    chk("sb_drained", q.size(), 0);

    // Asynchronous reset in the middle of a multiply
    drive(1'b1, 6'h00, 32'd5, 32'd7, 32'h500, 32'h000000B3, 32'hB0);
    step();
    drive(1'b1, 6'h02, 32'd9, 32'd9, 32'h504, 32'h000000C3, 32'hB1);
    step();
    in_valid = 1'b0;
    step();
    chk("arst_busy_before", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_id", out_id, NOP);
    chk("arst_y", out_y, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("arst_in_ready", in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
